// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data RAM between the CPU data port and the UART loader
module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock_i,
    input  logic              rst_i,
    input  logic              ld_mode_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_gnt_o,
    output logic [ADDR_W-1:0] ram_addra_o,
    output logic              ram_wea_o,
    output logic [DATA_W-1:0] ram_dina_o,
    input  logic [DATA_W-1:0] ram_douta_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;   // 1 = loader
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          ld_wait_q, ld_wait_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                cpu_ok;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr_i[31:ADDR_W+2], cpu_addr_i[1:0]};
    assign cpu_ok = cpu_req_i & ~ld_mode_i;

    always_ff @(posedge clock_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            ld_wait_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            ld_wait_q <= ld_wait_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        ld_wait_d = ld_wait_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                // The loader overrides CPU priority once it has lost MAX_WAIT decisions in a row
                if (ld_req_i && (!cpu_ok || ld_wait_q == MAX_WAIT_C)) begin
                    owner_d   = 1'b1;
                    addr_d    = ld_addr_i;
                    we_d      = 1'b1;
                    wdata_d   = ld_wdata_i;
                    ld_wait_d = '0;
                    state_d   = ISSUE;
                end else if (cpu_ok) begin
                    owner_d = 1'b0;
                    addr_d  = cpu_addr_i[ADDR_W+1:2];
                    we_d    = cpu_we_i;
                    wdata_d = cpu_wdata_i;
                    state_d = ISSUE;
                    if (ld_req_i && ld_wait_q != MAX_WAIT_C) begin
                        ld_wait_d = ld_wait_q + 4'd1;
                    end
                end
            end
            ISSUE:   state_d = we_q ? IDLE : RDWAIT;
            RDWAIT: begin
                rdata_d = ram_douta_i;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // addr_q only changes on the IDLE-to-ISSUE edge, so it naturally holds the last issued address
    assign ram_addra_o  = addr_q;
    assign ram_wea_o    = (state_q == ISSUE) & we_q;
    assign ram_dina_o   = (state_q == ISSUE) ? wdata_q : '0;
    assign cpu_gnt_o    = (state_q == ISSUE) & ~owner_q;
    assign ld_gnt_o     = (state_q == ISSUE) & owner_q;
    assign cpu_rvalid_o = (state_q == RESP);
    assign cpu_rdata_o  = rdata_q;
    assign cpu_stall_o  = rst_i & cpu_req_i
                        & ~(((state_q == ISSUE) & ~owner_q & we_q) | cpu_rvalid_o);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM block (synchronous read, 1-cycle read latency, one write-enable) between two requesters: the CPU data port and the UART program/data loader.
- Sits between the CPU load/store path and the RAM instance.
- Fixed CPU priority, with a starvation guard for the loader and a loader-exclusive mode used during programming.
- Generates the CPU stall signal that freezes the single-cycle core while an access is pending.

Parameters:
ADDR_W, 14, RAM word-address width
DATA_W, 32, data width
MAX_WAIT, 4, consecutive lost arbitration decisions after which the loader wins (1..15)

Ports:
clock  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low
ld_mode  in  1  1 = loader owns memory, CPU requests never granted
cpu_req  in  1  CPU access request, held until completion
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  32  CPU byte address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  one-cycle pulse, CPU access issued to RAM
cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
cpu_rdata  out  DATA_W  read data, held until the next CPU read completes
cpu_stall  out  1  CPU must hold its state
ld_req  in  1  loader write request, held until ld_gnt
ld_addr  in  ADDR_W  loader word address
ld_wdata  in  DATA_W  loader write data
ld_gnt  out  1  one-cycle pulse, loader write issued
ram_addra  out  ADDR_W  RAM address
ram_wea  out  1  RAM write enable
ram_dina  out  DATA_W  RAM write data
ram_douta  in  DATA_W  RAM read data, valid the cycle after the address is issued

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ld_wait=0.
  - All outputs are 0, including cpu_rdata and ram_*.
  - Takes effect immediately, mid-operation included: an in-flight wea drops in the same cycle, and the write is not guaranteed.
  - A pending rvalid is cancelled.
- States: IDLE, ISSUE, RDWAIT, RESP.
- IDLE arbitration, evaluated every cycle:
  - cpu_ok = cpu_req & ~ld_mode.
  - Loader wins if ld_req & (~cpu_ok | ld_wait==MAX_WAIT). Otherwise the CPU wins if cpu_ok.
  - With no eligible request, stay in IDLE.
  - On a winner: register owner, word address, we and wdata; go to ISSUE.
  - CPU word address = cpu_addr[ADDR_W+1:2]. cpu_addr[1:0] and the bits above ADDR_W+1 are ignored (word access, address wraps).
  - Loader accesses are always writes.
- ld_wait: 4-bit counter.
  - Increments (saturating at MAX_WAIT) on each IDLE decision where ld_req=1 and the CPU wins.
  - Clears when the loader wins.
  - Unchanged otherwise.
- ISSUE (1 cycle):
  - ram_addra, ram_wea (=registered we), ram_dina are driven from the registers.
  - The owner's gnt is 1.
  - Write: next state IDLE.
  - Read: next state RDWAIT.
- ram_* outputs are 0 in every state other than ISSUE, except that ram_addra holds its last value.
- RDWAIT (1 cycle): cpu_rdata <= ram_douta on the exiting edge; next state RESP.
- RESP (1 cycle): cpu_rvalid=1; next state IDLE.
- Latency (request first seen in IDLE at cycle 0):
  - gnt in cycle 1.
  - Write committed at the end of cycle 1; next arbitration in cycle 2.
  - Read: rvalid in cycle 3; next arbitration in cycle 4.
- Only one access is in flight; requests arriving outside IDLE wait.
- Requester signals are sampled only on the IDLE-to-ISSUE edge. A requester deasserting req before gnt is a protocol violation; the sampled access still completes.
- cpu_stall (combinational) = cpu_req & ~((state==ISSUE & owner==CPU & we) | cpu_rvalid).
  - Asserted while ld_mode=1 and cpu_req=1.
- ld_mode rising while a CPU access is past IDLE: that access completes normally.

Test Plan:
1. CPU write addr 0x10, data 0xDEADBEEF, then read 0x10 -> write: cpu_gnt cycle 1 with ram_addra=4, wea=1, dina=0xDEADBEEF; read: cpu_rvalid 2 cycles after its gnt, cpu_rdata=0xDEADBEEF; cpu_stall low exactly on the write gnt cycle and the rvalid cycle.
2. cpu_req (writes) and ld_req held continuously, MAX_WAIT=4 -> grant sequence CPU,CPU,CPU,CPU,LD,CPU...; ld_wait returns to 0 after the LD grant.
3. Loader only, writes 0xA0/0xA1/0xA2 to addresses 0,1,2 back-to-back -> ld_gnt every 2 cycles; ram_addra/ram_dina match each pair; wea high only on gnt cycles.
4. CPU read to 0x13 -> ram_addra=4 (byte offset ignored); read to 0x0001_0010 with ADDR_W=14 -> ram_addra=4 (wrap).
5. rst driven low during RDWAIT -> all outputs 0 in the same cycle; cpu_rvalid never pulses; after rst=1, a new CPU read is granted in cycle 1 normally.
6. ld_mode=1 with cpu_req=1 for 10 cycles -> no cpu_gnt, cpu_stall=1 throughout, loader still served; ld_mode->0 -> cpu_gnt on the next IDLE decision.
